// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave view; the byte source / memory side takes master.
`timescale 1ns/1ps
interface program_loader_if #(
  parameter int MEMORY_AWIDTH = 15,
  parameter int DWIDTH        = 32
);
  logic                     in_valid;
  logic [7:0]               in_byte;
  logic                     in_ready;
  logic                     mem_we;
  logic [MEMORY_AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0]        mem_wdata;

  modport master (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Streams a length-prefixed little-endian image into instruction memory,
// then releases the CPU from reset. start reloads from RUN or ERROR.
`timescale 1ns/1ps
module program_loader #(
  parameter int MEMORY_AWIDTH = 15,
  parameter int DWIDTH        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  program_loader_if.slave   bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {HDR, DATA, WRITE, RUN, ERROR} state_t;

  // One bit wider than the count so N == depth compares correctly.
  localparam logic [32:0] DEPTH = 33'(1) << MEMORY_AWIDTH;

  state_t                   state;
  logic [1:0]               byte_cnt;
  logic [31:0]              count;
  logic [MEMORY_AWIDTH-1:0] idx;
  logic [DWIDTH-1:0]        word;
  logic                     accept;
  logic [31:0]              hdr_next;
  logic [DWIDTH-1:0]        word_next;
  logic [31:0]              idx_inc;

  assign bus.in_ready = (state == HDR) || (state == DATA);
  assign accept       = bus.in_valid && bus.in_ready;
  assign hdr_next     = {bus.in_byte, count[31:8]};
  assign word_next    = {bus.in_byte, word[DWIDTH-1:8]};
  assign idx_inc      = 32'(idx) + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= HDR;
      byte_cnt      <= 2'd0;
      count         <= 32'd0;
      idx           <= '0;
      word          <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rst       <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        HDR: begin
          if (accept) begin
            count    <= hdr_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (hdr_next == 32'd0) begin
                state   <= RUN;
                cpu_rst <= 1'b0;
                done    <= 1'b1;
              end else if ({1'b0, hdr_next} > DEPTH) begin
                state <= ERROR;
                error <= 1'b1;
              end else begin
                state <= DATA;
                idx   <= '0;
              end
            end
          end
        end
        DATA: begin
          if (accept) begin
            word     <= word_next;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state         <= WRITE;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= idx;
              bus.mem_wdata <= word_next;
            end
          end
        end
        WRITE: begin
          // idx wraps to 0 after the last word of a full-depth image; unused then.
          idx <= idx_inc[MEMORY_AWIDTH-1:0];
          if (idx_inc == count) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
            done    <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        RUN: begin
          if (start) begin
            state    <= HDR;
            count    <= 32'd0;
            idx      <= '0;
            byte_cnt <= 2'd0;
            cpu_rst  <= 1'b1;
            done     <= 1'b0;
          end
        end
        ERROR: begin
          if (start) begin
            state    <= HDR;
            count    <= 32'd0;
            idx      <= '0;
            byte_cnt <= 2'd0;
            error    <= 1'b0;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, gapped load, empty image, oversize
// header, mid-load reset and reload, with hand-computed expectations.
`timescale 1ns/1ps
module tb_program_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_rst, done, error;

  int checks = 0;
  int errors = 0;

  program_loader_if #(.MEMORY_AWIDTH(15), .DWIDTH(32)) bus ();

  program_loader #(.MEMORY_AWIDTH(15), .DWIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus.slave),
    .cpu_rst (cpu_rst),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Write and byte-acceptance log.
  logic [14:0] wr_addr [0:63];
  logic [31:0] wr_data [0:63];
  int wr_n  = 0;
  int acc_n = 0;

  always @(posedge clk) begin
    if (bus.mem_we && wr_n < 64) begin
      wr_addr[wr_n] <= bus.mem_addr;
      wr_data[wr_n] <= bus.mem_wdata;
      wr_n          <= wr_n + 1;
    end
    if (bus.in_valid && bus.in_ready) acc_n <= acc_n + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    bus.in_valid = 1'b0;
    repeat (gap) cyc();
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    k = 0;
    while (!bus.in_ready && k < 40) begin
      cyc();
      k++;
    end
    if (k >= 40) begin
      checks++;
      errors++;
      $error("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, byte 0x%0h", k, b);
    end else begin
      cyc();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap));
      send_byte(w[8*i +: 8], g);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_cpu_rst"},  32'(cpu_rst),       32'd1);
    chk({pfx, "_done"},     32'(done),          32'd0);
    chk({pfx, "_error"},    32'(error),         32'd0);
    chk({pfx, "_in_ready"}, 32'(bus.in_ready),  32'd1);
    chk({pfx, "_mem_we"},   32'(bus.mem_we),    32'd0);
    chk({pfx, "_mem_addr"}, 32'(bus.mem_addr),  32'd0);
    chk({pfx, "_wdata"},    bus.mem_wdata,      32'd0);
  endtask

  initial begin
    int base;
    int abase;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // Reset state
    repeat (3) cyc();
    rst = 1'b0;
    chk_reset_outputs("rst");

    // Back-to-back two-word image
    base = wr_n;
    abase = acc_n;
    send_word(32'd2, 0);
    send_word(32'h0000_0013, 0);
    send_word(32'hDEAD_BEEF, 0);
    chk("a_we_t1",    32'(bus.mem_we),   32'd1);
    chk("a_addr_t1",  32'(bus.mem_addr), 32'd1);
    chk("a_data_t1",  bus.mem_wdata,     32'hDEAD_BEEF);
    chk("a_ready_t1", 32'(bus.in_ready), 32'd0);
    chk("a_done_t1",  32'(done),         32'd0);
    cyc();
    chk("a_done_t2",    32'(done),         32'd1);
    chk("a_cpu_rst_t2", 32'(cpu_rst),      32'd0);
    chk("a_we_t2",      32'(bus.mem_we),   32'd0);
    chk("a_nwrites",    32'(wr_n - base),  32'd2);
    chk("a_addr0",      32'(wr_addr[base]),     32'd0);
    chk("a_data0",      wr_data[base],          32'h0000_0013);
    chk("a_addr1",      32'(wr_addr[base + 1]), 32'd1);
    chk("a_data1",      wr_data[base + 1],      32'hDEAD_BEEF);
    chk("a_accepted",   32'(acc_n - abase), 32'd12);

    // Reload from RUN, then the same image with random valid gaps
    pulse_start();
    chk("r_cpu_rst",  32'(cpu_rst),       32'd1);
    chk("r_done",     32'(done),          32'd0);
    chk("r_in_ready", 32'(bus.in_ready),  32'd1);
    base = wr_n;
    abase = acc_n;
    send_word(32'd2, 3);
    send_word(32'h0000_0013, 3);
    send_word(32'hDEAD_BEEF, 3);
    cyc();
    chk("g_done",     32'(done),              32'd1);
    chk("g_cpu_rst",  32'(cpu_rst),           32'd0);
    chk("g_nwrites",  32'(wr_n - base),       32'd2);
    chk("g_addr0",    32'(wr_addr[base]),     32'd0);
    chk("g_data0",    wr_data[base],          32'h0000_0013);
    chk("g_addr1",    32'(wr_addr[base + 1]), 32'd1);
    chk("g_data1",    wr_data[base + 1],      32'hDEAD_BEEF);
    chk("g_accepted", 32'(acc_n - abase),     32'd12);

    // Empty image: done one cycle after the 4th header byte
    pulse_start();
    base = wr_n;
    send_word(32'd0, 0);
    chk("z_done",    32'(done),        32'd1);
    chk("z_cpu_rst", 32'(cpu_rst),     32'd0);
    chk("z_we",      32'(bus.mem_we),  32'd0);
    cyc();
    chk("z_nwrites", 32'(wr_n - base), 32'd0);

    // Oversize header 0x8001 (depth is 0x8000)
    pulse_start();
    base = wr_n;
    send_word(32'h0000_8001, 0);
    chk("e_error",    32'(error),          32'd1);
    chk("e_cpu_rst",  32'(cpu_rst),        32'd1);
    chk("e_in_ready", 32'(bus.in_ready),   32'd0);
    chk("e_done",     32'(done),           32'd0);
    repeat (3) cyc();
    chk("e_error_hold", 32'(error),        32'd1);
    chk("e_nwrites",    32'(wr_n - base),  32'd0);

    // Recover via start, then a one-word image
    pulse_start();
    chk("e_error_clr", 32'(error),         32'd0);
    chk("e_ready_clr", 32'(bus.in_ready),  32'd1);
    base = wr_n;
    send_word(32'd1, 0);
    send_word(32'h1234_5678, 0);
    cyc();
    chk("e1_nwrites", 32'(wr_n - base),    32'd1);
    chk("e1_addr",    32'(wr_addr[base]),  32'd0);
    chk("e1_data",    wr_data[base],       32'h1234_5678);
    chk("e1_done",    32'(done),           32'd1);
    chk("e1_error",   32'(error),          32'd0);

    // Header whose low 16 bits are zero must still be rejected
    pulse_start();
    send_word(32'h0100_0000, 0);
    chk("big_error", 32'(error), 32'd1);
    chk("big_done",  32'(done),  32'd0);
    pulse_start();

    // Reset in the middle of a three-word image
    base = wr_n;
    send_word(32'd3, 0);
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    send_byte(8'h33, 0);
    send_byte(8'h33, 0);
    chk("m_nwrites", 32'(wr_n - base),       32'd2);
    chk("m_addr1",   32'(wr_addr[base + 1]), 32'd1);
    rst = 1'b1;
    cyc();
    chk_reset_outputs("m");
    rst = 1'b0;
    base = wr_n;
    send_word(32'd1, 0);
    send_word(32'hCAFE_F00D, 0);
    cyc();
    chk("m1_nwrites", 32'(wr_n - base),   32'd1);
    chk("m1_addr",    32'(wr_addr[base]), 32'd0);
    chk("m1_data",    wr_data[base],      32'hCAFE_F00D);
    chk("m1_done",    32'(done),          32'd1);
    chk("m1_cpu_rst", 32'(cpu_rst),       32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image into the CPU's instruction memory over a byte-wide valid/ready link, then releases the CPU from reset. It is the write side of the program memory the CPU fetches from. It sits between the host/debug byte source and the instruction-memory write port, and it owns the CPU's `pc_rst` line. It replaces the static `PROGRAM_FILE` preload when the image must change without resynthesis.

## Interface
- `MEMORY_AWIDTH`, 15, instruction-memory word-address width; depth = 2**MEMORY_AWIDTH words
- `DWIDTH`, 32, instruction word width; fixed at 32, other values unsupported

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; restarts a load from RUN or ERROR
- `in_valid`  in  1  byte source has data
- `in_byte`  in  8  image byte
- `in_ready`  out  1  loader accepts byte this cycle
- `mem_we`  out  1  instruction-memory write strobe, one cycle per word
- `mem_addr`  out  MEMORY_AWIDTH  word address
- `mem_wdata`  out  DWIDTH  word data
- `cpu_rst`  out  1  drives CPU `pc_rst`; high while loading
- `done`  out  1  image loaded, CPU running
- `error`  out  1  header word count exceeds memory depth

## Operation
- Image format:
  - 4-byte little-endian word count N.
  - Then N words, each sent as 4 bytes, little-endian (first byte goes to bits 7:0).
- A byte transfers only when `in_valid && in_ready` at a rising edge. `in_byte` is ignored otherwise.
- FSM states: HDR, DATA, WRITE, RUN, ERROR.
  - HDR: `in_ready`=1. Accumulate 4 bytes into a 32-bit count.
    - On the 4th byte, if N=0, go to RUN.
    - If N > 2**MEMORY_AWIDTH, go to ERROR.
    - Otherwise go to DATA with word index 0.
  - DATA: `in_ready`=1. Accumulate 4 bytes into a word shift register. On the 4th byte, go to WRITE.
  - WRITE: `in_ready`=0.
    - Assert `mem_we` for one cycle with `mem_addr`=word index and `mem_wdata`=assembled word.
    - Increment the index. If index+1 == N go to RUN, else go to DATA.
  - RUN: `in_ready`=0, `cpu_rst`=0, `done`=1. `start` returns to HDR, clears count/index/byte counter, and re-asserts `cpu_rst`.
  - ERROR: `in_ready`=0, `cpu_rst`=1, `error`=1. Leaves only on `start` (to HDR) or `rst`.
- `start` is ignored in HDR, DATA and WRITE.
- `mem_addr` increments from 0 to N-1 with no wrap. N = 2**MEMORY_AWIDTH writes address 2**MEMORY_AWIDTH-1 last and is legal.
- Count compare uses the full 32-bit N; no truncation before the compare.
- The byte counter is 2 bits. It wraps 3->0 on the last byte of the header and of each word.

## Timing
- Reset values:
  - state=HDR, `in_ready`=1 (state-decoded)
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `cpu_rst`=1, `done`=0, `error`=0
  - internal counters cleared
- `rst` mid-load aborts immediately. Words already written stay in memory; the next image overwrites them.
- All outputs except `in_ready` are registered.
- Latencies, with the 4th byte of a word accepted at edge t:
  - `mem_we`=1 during cycle t+1.
  - `in_ready`=0 during t+1 and returns to 1 in t+2 if more words remain.
  - Peak throughput is one word per 5 cycles.
- Last write in cycle t+1: `cpu_rst` falls and `done` rises at edge t+2, both in the same cycle.
- N=0: `cpu_rst` falls and `done` rises one cycle after the 4th header byte is accepted.
- `in_valid` may drop at any byte boundary. The loader waits indefinitely, with no timeout.
- `start` and `rst` in the same cycle: `rst` wins.

## Test plan
- After `rst`: `cpu_rst`=1, `done`=0, `in_ready`=1, `mem_we`=0. Send N=2, words 0x00000013, 0xDEADBEEF as 12 back-to-back bytes. Required:
  - exactly two `mem_we` pulses, addr 0 data 0x00000013, then addr 1 data 0xDEADBEEF;
  - `done`=1 and `cpu_rst`=0 two cycles after the last byte is accepted.
- Same image with `in_valid` toggled pseudo-randomly (gaps of 0-3 cycles). Required: identical write sequence, no byte lost or duplicated, no write while `in_ready`=0.
- N=0 header (00 00 00 00): no `mem_we`; `done`=1 and `cpu_rst`=0 one cycle after the 4th byte.
- N=0x00008001 with MEMORY_AWIDTH=15: `error`=1, `cpu_rst` stays 1, `in_ready`=0, no writes. Then pulse `start`, send N=1 with word 0x12345678: write at addr 0, `error`=0, `done`=1.
- Reset mid-load: assert `rst` after 2 of 3 words are written. Required: outputs return to reset values next cycle. Then a fresh N=1 image writes addr 0 and asserts `done`.
- Reload from RUN: pulse `start`. Required: `cpu_rst`=1 and `done`=0 next cycle, `in_ready`=1; a second image writes from addr 0 again.
